// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one 32-bit restoring divider between NREQ requesters.
// Latency: req_ready at T, div_init at T+1, rsp_valid at T+35; responses are not back-pressured.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_dividend,
  input  logic [NREQ*32-1:0]   req_divisor,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_quot,
  output logic [31:0]          rsp_rem,
  output logic                 rsp_dz,
  output logic                 div_init,
  output logic [31:0]          div_dividend,
  output logic [31:0]          div_divisor,
  input  logic [63:0]          div_rslt,
  input  logic                 div_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic            guard_q;
  logic [IDW-1:0]  last_q, cur_id_q;
  logic [IDW-1:0]  win_id, cand;
  logic            win_found, grant, capture;
  logic [NREQ-1:0] req_ready_d;
  logic            div_init_d;
  int              idx;
  logic [31:0]     dvd_a [NREQ];
  logic [31:0]     dvs_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign dvd_a[g] = req_dividend[32*g +: 32];
    assign dvs_a[g] = req_divisor[32*g +: 32];
  end

  // Search upward from last+1 with wrap-around; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // The capture edge doubles as an idle slot so back-to-back grants are 35 cycles apart.
  assign capture = (state_q == S_WAIT) && !guard_q && !div_busy;
  assign grant   = win_found && !div_busy && ((state_q == S_IDLE) || capture);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (capture) state_d = grant ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    if (grant) req_ready_d[win_id] = 1'b1;
    div_init_d = (state_q == S_ISSUE);
  end

  // div_dividend/div_divisor double as the latched operands of the owning request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      guard_q      <= 1'b0;
      last_q       <= IDW'(NREQ - 1);
      cur_id_q     <= '0;
      req_ready    <= '0;
      div_init     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quot     <= '0;
      rsp_rem      <= '0;
      rsp_dz       <= 1'b0;
    end else begin
      guard_q   <= (state_q == S_ISSUE);
      req_ready <= req_ready_d;
      div_init  <= div_init_d;
      rsp_valid <= capture;
      if (grant) begin
        last_q       <= win_id;
        cur_id_q     <= win_id;
        div_dividend <= dvd_a[win_id];
        div_divisor  <= dvs_a[win_id];
      end
      if (capture) begin
        rsp_id   <= cur_id_q;
        rsp_quot <= div_rslt[31:0];
        rsp_rem  <= div_rslt[63:32];
        rsp_dz   <= (div_divisor == '0);
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with a behavioural divider that is busy 32 cycles at power-up and per divide.
module tb_div_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*32-1:0]  req_dividend = '0;
  logic [NREQ*32-1:0]  req_divisor = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_quot, rsp_rem;
  logic                rsp_dz, div_init;
  logic [31:0]         div_dividend, div_divisor;
  logic [63:0]         div_rslt = '0;
  logic                div_busy;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rsp_cnt = 0, exp_rsp = 0;
  int model_last = NREQ - 1;
  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];

  div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz),
    .div_init(div_init), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_rslt(div_rslt), .div_busy(div_busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // {remainder, quotient}; division by zero yields all-ones quotient and the dividend as remainder.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Divider stand-in: never reset, busy 32 cycles after power-up and after each init.
  int          dv_cnt = 32;
  logic [63:0] dv_pend = '0;
  assign div_busy = (dv_cnt != 0);
  always @(posedge CLK) begin
    if (div_init && dv_cnt == 0) begin
      dv_cnt  <= 32;
      dv_pend <= ref_div(div_dividend, div_divisor);
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) div_rslt <= dv_pend;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    opa[i] = a;
    opb[i] = b;
    req_dividend[i*32 +: 32] = a;
    req_divisor[i*32 +: 32]  = b;
  endtask

  function automatic logic [31:0] rnd_dvs();
    if ($urandom_range(0, 4) == 0) return 32'd0;
    return 32'($urandom_range(1, 70000));
  endfunction

  // ti is the first sampled cycle with the divider idle but no grant yet (-1 if none).
  task automatic wait_grant(input int bound, output logic [NREQ-1:0] r, output int tg, output int ti);
    r = '0; tg = -1; ti = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (req_ready != '0) begin
        r  = req_ready;
        tg = cyc;
        break;
      end
      if (!div_busy && ti < 0) ti = cyc;
    end
    check("grant_seen", 64'(tg >= 0), 64'd1);
  endtask

  task automatic wait_rsp(input int bound, output int tr);
    tr = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        tr = cyc;
        break;
      end
    end
    check("rsp_seen", 64'(tr >= 0), 64'd1);
  endtask

  task automatic run_one(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_rq, input logic exp_dz, input bit gated);
    logic [NREQ-1:0] r;
    int tg, tr, ti;
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    wait_grant(300, r, tg, ti);
    req_valid[id] = 1'b0;
    check({tag, ".grant"}, 64'(r), 64'(1) << id);
    if (gated) check({tag, ".gate"}, 64'(tg), 64'(ti + 1));
    @(negedge CLK);
    check({tag, ".init"}, 64'(div_init), 64'd1);
    check({tag, ".opnd"}, {div_dividend, div_divisor}, {a, b});
    wait_rsp(60, tr);
    check({tag, ".lat"}, 64'(tr - tg), 64'd35);
    check({tag, ".id"}, 64'(rsp_id), 64'(id));
    check({tag, ".quot"}, 64'(rsp_quot), 64'(exp_rq[31:0]));
    check({tag, ".rem"}, 64'(rsp_rem), 64'(exp_rq[63:32]));
    check({tag, ".dz"}, 64'(rsp_dz), 64'(exp_dz));
    exp_rsp++;
    model_last = id;
    @(negedge CLK);
    check({tag, ".pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [31:0]     a, b;
    logic [63:0]     cur_exp;
    logic            cur_dz;
    int              tg, tr, ti, w, cur_id, id;

    repeat (3) @(negedge CLK);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.div_init", 64'(div_init), 64'd0);
    check("rst.rsp_dz", 64'(rsp_dz), 64'd0);
    check("rst.rsp_id", 64'(rsp_id), 64'd0);
    check("rst.rsp_quot", 64'(rsp_quot), 64'd0);
    check("rst.rsp_rem", 64'(rsp_rem), 64'd0);
    check("rst.div_dividend", 64'(div_dividend), 64'd0);
    check("rst.div_divisor", 64'(div_divisor), 64'd0);
    RST = 1'b0;

    // Divider still in its power-up busy window.
    a = $urandom;
    b = 32'($urandom_range(1, 70000));
    run_one("boot", 0, a, b, ref_div(a, b), 1'b0, 1'b1);

    run_one("single", 2, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
    run_one("dz", 1, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      id = $urandom_range(0, NREQ - 1);
      a  = $urandom;
      b  = rnd_dvs();
      run_one("rand", id, a, b, ref_div(a, b), (b == 0), 1'b0);
    end
    run_one("max", 0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 1'b0);
    run_one("small", 3, 32'd5, 32'd9, {32'd5, 32'd0}, 1'b0, 1'b0);

    // All requesters continuously valid: grants rotate from last+1, one every 35 cycles.
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, rnd_dvs());
    req_valid = '1;
    wait_grant(60, r, tg, ti);
    w = (model_last + 1) % NREQ;
    check("rr.grant", 64'(r), 64'(1) << w);
    cur_id = w; cur_exp = ref_div(opa[w], opb[w]); cur_dz = (opb[w] == 0);
    model_last = w;
    set_op(w, $urandom, rnd_dvs());
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_valid = '0;
      wait_rsp(60, tr);
      check("rr.lat", 64'(tr - tg), 64'd35);
      check("rr.id", 64'(rsp_id), 64'(cur_id));
      check("rr.quot", 64'(rsp_quot), 64'(cur_exp[31:0]));
      check("rr.rem", 64'(rsp_rem), 64'(cur_exp[63:32]));
      check("rr.dz", 64'(rsp_dz), 64'(cur_dz));
      exp_rsp++;
      if (k < 4) begin
        w = (model_last + 1) % NREQ;
        check("rr.grant", 64'(req_ready), 64'(1) << w);
        tg = tr;
        cur_id = w; cur_exp = ref_div(opa[w], opb[w]); cur_dz = (opb[w] == 0);
        model_last = w;
        set_op(w, $urandom, rnd_dvs());
      end else begin
        check("rr.idle", 64'(req_ready), 64'd0);
      end
    end
    repeat (2) @(negedge CLK);

    // Reset ten cycles into a divide; the abandoned result must never surface.
    set_op(2, $urandom, 32'($urandom_range(1, 70000)));
    req_valid[2] = 1'b1;
    wait_grant(20, r, tg, ti);
    req_valid[2] = 1'b0;
    check("abort.grant", 64'(r), 64'b0100);
    while (cyc < tg + 10) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("abort.rst_quot", 64'(rsp_quot), 64'd0);
    RST = 1'b0;
    model_last = NREQ - 1;
    run_one("rst", 1, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 1'b1);

    repeat (40) @(negedge CLK);
    check("rsp_count", 64'(rsp_cnt), 64'(exp_rsp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
